// File: rtl/strip_reconfig_sequencer.sv
// Click-free filter reconfiguration: fade gain out, load each changed filter over req/ack, fade back in.
// Optional build macro STRIP_ACK_TIMEOUT_EN adds an ack timeout and the sticky load_err output.
module strip_reconfig_sequencer #(
    parameter int GAIN_W    = 8,
    parameter int GAIN_STEP = 4
`ifdef STRIP_ACK_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk_48,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic              mute,
    input  logic [2:0]        freqSelect,
    input  logic [2:0]        lowpassSelect,
    input  logic [2:0]        highpassSelect,
    output logic              load_req,
    output logic [1:0]        load_target,
    output logic [2:0]        load_sel,
    input  logic              load_ack,
    output logic [GAIN_W-1:0] gain,
    output logic              busy,
    output logic [2:0]        state_o
`ifdef STRIP_ACK_TIMEOUT_EN
    , output logic            load_err
`endif
);
    // Handshake: load_req rises with load_target/load_sel valid and holds them
    // stable until a load_ack pulse is seen while load_req is high.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FADE_OUT = 3'd1,
        LOAD     = 3'd2,
        WAIT_ACK = 3'd3,
        FADE_IN  = 3'd4,
        MUTED    = 3'd5
    } state_t;

    localparam logic [GAIN_W-1:0] GMAX = '1;
    localparam logic [GAIN_W-1:0] STEP = GAIN_W'(GAIN_STEP);

    state_t            state_q;
    logic [GAIN_W-1:0] gain_q;
    logic              load_req_q;
    logic [1:0]        load_target_q;
    logic [2:0]        load_sel_q;
    logic [2:0][2:0]   applied_q;
    logic [2:0]        force_q;

    logic [2:0][2:0]   sel_in;
    logic [2:0]        pending;
    logic [2:0]        pending_ack;
    logic [1:0]        pick;
    logic [GAIN_W-1:0] gain_dn;
    logic [GAIN_W-1:0] gain_up;
    logic              load_done;

    assign sel_in = {highpassSelect, lowpassSelect, freqSelect};

    // pending_ack is the pending set as it will look once the in-flight load lands.
    always_comb begin
        pending     = '0;
        pending_ack = '0;
        for (int t = 0; t < 3; t++) begin
            pending[t]     = force_q[t] | (sel_in[t] != applied_q[t]);
            pending_ack[t] = (2'(t) == load_target_q) ? (sel_in[t] != load_sel_q) : pending[t];
        end
    end

    always_comb begin
        pick = 2'd0;
        if (pending[0])      pick = 2'd0;
        else if (pending[1]) pick = 2'd1;
        else if (pending[2]) pick = 2'd2;
    end

    assign gain_dn = (gain_q > STEP) ? (gain_q - STEP) : '0;
    assign gain_up = ((GMAX - gain_q) > STEP) ? (gain_q + STEP) : GMAX;

`ifdef STRIP_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] ack_cnt_q;
    logic             load_err_q;
    logic             ack_timeout;
    assign ack_timeout = (ack_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign load_done   = load_req_q & (load_ack | ack_timeout);
    assign load_err    = load_err_q;
`else
    assign load_done = load_req_q & load_ack;
`endif

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q       <= FADE_OUT;
            gain_q        <= '0;
            load_req_q    <= 1'b0;
            load_target_q <= 2'd0;
            load_sel_q    <= 3'd0;
            applied_q     <= {3'd2, 3'd1, 3'd4};
            force_q       <= 3'b111;
`ifdef STRIP_ACK_TIMEOUT_EN
            ack_cnt_q     <= '0;
            load_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    gain_q <= GMAX;
                    if ((|pending) || mute) state_q <= FADE_OUT;
                end
                FADE_OUT: begin
                    if (gain_q == '0) begin
                        if (|pending)  state_q <= LOAD;
                        else if (mute) state_q <= MUTED;
                        else           state_q <= FADE_IN;
                    end else if (sample_tick) begin
                        gain_q <= gain_dn;
                    end
                end
                LOAD: begin
                    // Inputs may have reverted since the fade started; then nothing is loaded.
                    if (|pending) begin
                        load_target_q <= pick;
                        load_sel_q    <= sel_in[pick];
                        load_req_q    <= 1'b1;
                        state_q       <= WAIT_ACK;
`ifdef STRIP_ACK_TIMEOUT_EN
                        ack_cnt_q     <= '0;
`endif
                    end else if (mute) begin
                        state_q <= MUTED;
                    end else begin
                        state_q <= FADE_IN;
                    end
                end
                WAIT_ACK: begin
                    if (load_done) begin
                        applied_q[load_target_q] <= load_sel_q;
                        force_q[load_target_q]   <= 1'b0;
                        load_req_q               <= 1'b0;
                        if (|pending_ack) state_q <= LOAD;
                        else if (mute)    state_q <= MUTED;
                        else              state_q <= FADE_IN;
`ifdef STRIP_ACK_TIMEOUT_EN
                        if (!load_ack) load_err_q <= 1'b1;
`endif
                    end
`ifdef STRIP_ACK_TIMEOUT_EN
                    else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
`endif
                end
                FADE_IN: begin
                    if ((|pending) || mute) begin
                        state_q <= FADE_OUT;
                    end else if (gain_q == GMAX) begin
                        state_q <= IDLE;
                    end else if (sample_tick) begin
                        gain_q <= gain_up;
                    end
                end
                MUTED: begin
                    gain_q <= '0;
                    if (|pending)  state_q <= LOAD;
                    else if (!mute) state_q <= FADE_IN;
                end
                default: state_q <= FADE_OUT;
            endcase
        end
    end

    assign load_req    = load_req_q;
    assign load_target = load_target_q;
    assign load_sel    = load_sel_q;
    assign gain        = gain_q;
    assign busy        = (state_q != IDLE);
    assign state_o     = state_q;
endmodule

// File: tb/tb_strip_reconfig_sequencer.sv
// Directed bench for strip_reconfig_sequencer: reset reload, single loads, mute, mid-fade and mid-load changes.
module tb_strip_reconfig_sequencer;
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FADE_OUT = 3'd1;
    localparam logic [2:0] S_LOAD     = 3'd2;
    localparam logic [2:0] S_FADE_IN  = 3'd4;
    localparam logic [2:0] S_MUTED    = 3'd5;

    logic       clk_48 = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       mute;
    logic [2:0] freqSelect;
    logic [2:0] lowpassSelect;
    logic [2:0] highpassSelect;
    logic       load_req;
    logic [1:0] load_target;
    logic [2:0] load_sel;
    logic       load_ack;
    logic [7:0] gain;
    logic       busy;
    logic [2:0] state_o;

    int passed = 0;
    int total  = 0;

    strip_reconfig_sequencer dut (
        .clk_48        (clk_48),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .mute          (mute),
        .freqSelect    (freqSelect),
        .lowpassSelect (lowpassSelect),
        .highpassSelect(highpassSelect),
        .load_req      (load_req),
        .load_target   (load_target),
        .load_sel      (load_sel),
        .load_ack      (load_ack),
        .gain          (gain),
        .busy          (busy),
        .state_o       (state_o)
    );

    always #10 clk_48 = ~clk_48;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            @(negedge clk_48);
            sample_tick = 1'b0;
            @(negedge clk_48);
        end
    endtask

    task automatic wait_req(input int budget);
        int n;
        n = 0;
        while (!load_req && n < budget) begin
            @(negedge clk_48);
            n++;
        end
        check("req_seen", load_req, 1);
    endtask

    // Ack arrives two cycles after the request is first seen.
    task automatic do_load(input logic [1:0] exp_t, input logic [2:0] exp_s);
        wait_req(50);
        check("load_target", load_target, exp_t);
        check("load_sel", load_sel, exp_s);
        @(negedge clk_48);
        check("req_held", load_req, 1);
        load_ack = 1'b1;
        @(negedge clk_48);
        load_ack = 1'b0;
        check("req_dropped", load_req, 0);
    endtask

    task automatic fade_in_to_idle(input string tag);
        ticks(63);
        check({tag, "_gain_252"}, gain, 252);
        ticks(1);
        check({tag, "_gain_255"}, gain, 255);
        check({tag, "_idle"}, state_o, S_IDLE);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; mute = 1'b0; load_ack = 1'b0;
        freqSelect = 3'd4; lowpassSelect = 3'd1; highpassSelect = 3'd2;
        repeat (3) @(negedge clk_48);
        check("rst_state", state_o, S_FADE_OUT);
        check("rst_gain", gain, 0);
        check("rst_req", load_req, 0);
        check("rst_target", load_target, 0);
        check("rst_sel", load_sel, 0);
        check("rst_busy", busy, 1);

        // Reset reload of all three filters with unchanged inputs.
        reset = 1'b0;
        do_load(2'd0, 3'd4);
        do_load(2'd1, 3'd1);
        do_load(2'd2, 3'd2);
        check("boot_fade_in", state_o, S_FADE_IN);
        fade_in_to_idle("boot");

        // Ack and tick outside their states do nothing.
        load_ack = 1'b1; sample_tick = 1'b1;
        @(negedge clk_48);
        load_ack = 1'b0; sample_tick = 1'b0;
        @(negedge clk_48);
        check("stray_state", state_o, S_IDLE);
        check("stray_gain", gain, 255);
        check("stray_req", load_req, 0);

        // Single lowpass change.
        lowpassSelect = 3'd3;
        @(negedge clk_48);
        check("lp_fade_out", state_o, S_FADE_OUT);
        ticks(63);
        check("lp_gain_3", gain, 3);
        ticks(1);
        check("lp_gain_0", gain, 0);
        check("lp_load_state", state_o, S_LOAD);
        do_load(2'd1, 3'd3);
        fade_in_to_idle("lp");

        // Mute: fade out, sit in MUTED without loads, fade back in.
        mute = 1'b1;
        @(negedge clk_48);
        check("mute_fade_out", state_o, S_FADE_OUT);
        ticks(64);
        check("mute_gain", gain, 0);
        check("mute_state", state_o, S_MUTED);
        repeat (5) @(negedge clk_48);
        check("mute_no_req", load_req, 0);
        check("mute_hold", state_o, S_MUTED);
        mute = 1'b0;
        @(negedge clk_48);
        check("unmute_fade_in", state_o, S_FADE_IN);
        fade_in_to_idle("unmute");

        // Freq change in the middle of a fade-in reverses from the current gain.
        mute = 1'b1;
        @(negedge clk_48);
        ticks(64);
        mute = 1'b0;
        @(negedge clk_48);
        ticks(32);
        check("mid_gain_128", gain, 128);
        freqSelect = 3'd6;
        @(negedge clk_48);
        check("mid_reverse", state_o, S_FADE_OUT);
        check("mid_no_jump", gain, 128);
        ticks(1);
        check("mid_gain_124", gain, 124);
        ticks(31);
        check("mid_gain_0", gain, 0);
        do_load(2'd0, 3'd6);
        fade_in_to_idle("mid");

        // Highpass change while its own load is in flight.
        reset = 1'b1;
        @(negedge clk_48);
        reset = 1'b0;
        do_load(2'd0, 3'd6);
        do_load(2'd1, 3'd3);
        wait_req(50);
        check("hp_target", load_target, 2);
        check("hp_sel_old", load_sel, 2);
        highpassSelect = 3'd3;
        @(negedge clk_48);
        check("hp_sel_stable", load_sel, 2);
        check("hp_req_held", load_req, 1);
        load_ack = 1'b1;
        @(negedge clk_48);
        load_ack = 1'b0;
        check("hp_req_drop", load_req, 0);
        do_load(2'd2, 3'd3);
        fade_in_to_idle("hp");

        // Reset while waiting for an ack aborts and restarts the full reload.
        lowpassSelect = 3'd5;
        @(negedge clk_48);
        ticks(64);
        wait_req(50);
        check("abort_target", load_target, 1);
        check("abort_sel", load_sel, 5);
        reset = 1'b1;
        @(negedge clk_48);
        check("abort_req", load_req, 0);
        check("abort_gain", gain, 0);
        check("abort_state", state_o, S_FADE_OUT);
        check("abort_busy", busy, 1);
        reset = 1'b0;
        do_load(2'd0, 3'd6);
        do_load(2'd1, 3'd5);
        do_load(2'd2, 3'd3);
        fade_in_to_idle("abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/strip_reconfig_sequencer.md
Name: strip_reconfig_sequencer

Overview:
Sequences configuration changes of the channel-strip filters without audible clicks. It watches the encoded selections (EQ frequency, lowpass, highpass) and mute. On any change it fades the output gain to zero, then issues one load request per changed filter over a req/ack handshake, then fades the gain back up. It sits between the button encoder and the filter coefficient/gain datapath.

Parameters:
GAIN_W, 8, width of gain output; full scale GMAX = 2^GAIN_W-1
GAIN_STEP, 4, gain change per sample_tick during fades
TIMEOUT_CYCLES, 1024, ack timeout in clk_48 cycles (used only with the optional feature)

Ports:
clk_48  in  1  system clock, 48 MHz
reset  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle pulse at the audio sample rate
mute  in  1  mute request level
freqSelect  in  3  requested EQ frequency index
lowpassSelect  in  3  requested lowpass index
highpassSelect  in  3  requested highpass index
load_req  out  1  filter load request
load_target  out  2  0=EQ freq, 1=lowpass, 2=highpass; 3 never driven
load_sel  out  3  selection value to load
load_ack  in  1  one-cycle acknowledge from datapath
gain  out  GAIN_W  output gain to the datapath
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: clk_48 and reset are a single clock domain; reset is synchronous and active-high. Reset values: state=FADE_OUT, gain=0, load_req=0, load_target=0, load_sel=0, busy=1. Applied regs are set to 4/1/2 and force mask to 3'b111, so all three filters reload after reset. Reset asserted mid-operation aborts immediately; no ack is awaited.
- pending[t] = force[t] | (input_t != applied_t), evaluated combinationally every cycle.
- IDLE: gain=GMAX. If any pending or mute is set -> FADE_OUT in the next cycle.
- FADE_OUT: on each sample_tick, gain = max(gain-GAIN_STEP, 0). When gain==0, with no tick needed:
  - any pending -> LOAD
  - else mute -> MUTED
  - else -> FADE_IN
- LOAD (1 cycle):
  - pick the lowest-index pending target (priority EQ > LP > HP)
  - latch load_target and load_sel from the current input
  - assert load_req next cycle and go to WAIT_ACK.
- WAIT_ACK:
  - load_req held high; load_target and load_sel held stable.
  - On load_ack: applied_t = latched load_sel, force[t] cleared, load_req=0 next cycle.
  - Exit on the same edge: any pending -> LOAD; else mute -> MUTED; else -> FADE_IN.
  - An input change during WAIT_ACK does not alter the in-flight value. It shows up as pending afterwards.
- FADE_IN: on each sample_tick, gain = min(gain+GAIN_STEP, GMAX). If pending or mute appears, go to FADE_OUT from the current gain (no jump). At gain==GMAX -> IDLE.
- MUTED: gain=0. Any pending -> LOAD. Mute clear with none pending -> FADE_IN.
- load_ack received while load_req=0 is ignored.
- sample_tick is ignored outside FADE_OUT and FADE_IN.
- Full fade at defaults: 64 ticks (255 -> 3 -> 0; 0 -> 252 -> 255).
- Arithmetic is saturating; gain never wraps.

Optional Feature:
STRIP_ACK_TIMEOUT_EN:
- Defined:
  - a counter runs during WAIT_ACK.
  - At TIMEOUT_CYCLES with no ack: drop load_req, set the sticky output load_err (1 bit, reset 0, cleared only by reset), and treat the load as complete (applied and force updated).
  - FSM continues as if acked.
- Undefined: no counter and no load_err port; WAIT_ACK waits indefinitely.

Test Plan:
- Release reset with inputs 4/1/2, mute=0, ack returned 2 cycles after each req -> three loads in order (target 0 sel 4, target 1 sel 1, target 2 sel 2), then gain reaches 255 after 64 ticks, busy=0.
- In IDLE, change lowpassSelect 1->3 -> 64 ticks to gain 0, single load (target 1, sel 3), 64 ticks back to 255.
- Assert mute in IDLE -> fade to 0, state MUTED, no load_req. Release mute -> fade to 255.
- Change freqSelect to 6 during FADE_IN at gain 128 -> gain decrements 128->124 on the next tick, then load target 0 sel 6.
- Change highpassSelect 2->3 while WAIT_ACK is active for target 2 sel 2 -> req keeps sel 2 until ack, then a second load with sel 3 follows.
- Assert reset during WAIT_ACK -> next cycle load_req=0, gain=0, and the reload sequence restarts with all three targets.
